// File: rtl/sudoku_pkg.sv
// Shared types for the sudoku command executor: grid constants, FSM states,
// the buffered command entry and the cell-index helper.
package sudoku_pkg;

  localparam int GRID_N = 9;
  localparam int CELLS  = 81;

  typedef enum logic [2:0] {
    ST_SCAN,
    ST_IDLE,
    ST_EXEC,
    ST_ADDR,
    ST_CHECK
  } state_t;

  typedef struct packed {
    logic       up;
    logic       down;
    logic       left;
    logic       right;
    logic [3:0] number;
  } cmd_t;

  // y*9+x as (y<<3)+y+x; always fits in 7 bits for an on-grid cursor
  function automatic logic [6:0] cell_index(logic [3:0] x, logic [3:0] y);
    logic [6:0] y7;
    y7 = {3'b000, y};
    return (y7 << 3) + y7 + {3'b000, x};
  endfunction

endpackage

// File: rtl/sudoku_cmd_exec_if.sv
// Command strobe, cell RAM port and status bundle of the sudoku command executor.
interface sudoku_cmd_exec_if;
  logic       cmd_up;
  logic       cmd_down;
  logic       cmd_left;
  logic       cmd_right;
  logic [3:0] cmd_number;
  logic       cmd_valid;
  logic       cmd_drop;
  logic       cmd_err;

  logic [6:0] cell_addr;
  logic [3:0] cell_rdata;
  logic       cell_fixed;
  logic       cell_we;
  logic [3:0] cell_wdata;

  logic [3:0] cur_x;
  logic [3:0] cur_y;
  logic [3:0] cur_val;
  logic [6:0] filled_count;
  logic       grid_full;
  logic       ready;
  logic       busy;

  modport slave (
    input  cmd_up, cmd_down, cmd_left, cmd_right, cmd_number, cmd_valid,
    input  cell_rdata, cell_fixed,
    output cmd_drop, cmd_err, cell_addr, cell_we, cell_wdata,
    output cur_x, cur_y, cur_val, filled_count, grid_full, ready, busy
  );

  modport master (
    output cmd_up, cmd_down, cmd_left, cmd_right, cmd_number, cmd_valid,
    output cell_rdata, cell_fixed,
    input  cmd_drop, cmd_err, cell_addr, cell_we, cell_wdata,
    input  cur_x, cur_y, cur_val, filled_count, grid_full, ready, busy
  );
endinterface

// File: rtl/sudoku_cmd_fifo.sv
// Command buffer: power-of-two circular FIFO with fall-through head read.
module sudoku_cmd_fifo
  import sudoku_pkg::*;
#(
  parameter int FIFO_DEPTH = 4
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          i_push,
  input  logic                          i_pop,
  input  cmd_t                          i_data,
  output cmd_t                          o_data,
  output logic                          o_full,
  output logic                          o_empty,
  output logic [$clog2(FIFO_DEPTH):0]   o_count
);

  localparam int AW = $clog2(FIFO_DEPTH);

  cmd_t            r_mem [FIFO_DEPTH];
  logic [AW-1:0]   r_wptr;
  logic [AW-1:0]   r_rptr;
  logic [AW:0]     r_count;
  logic            w_push;
  logic            w_pop;

  assign o_full  = (r_count == (AW+1)'(FIFO_DEPTH));
  assign o_empty = (r_count == '0);
  assign o_count = r_count;
  assign o_data  = r_mem[r_rptr];

  // A full FIFO refuses the push even when a pop frees a slot this cycle
  assign w_push = i_push && !o_full;
  assign w_pop  = i_pop && !o_empty;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
    end else begin
      if (w_push) r_wptr <= r_wptr + AW'(1);
      if (w_pop)  r_rptr <= r_rptr + AW'(1);
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + (AW+1)'(1);
        2'b01:   r_count <= r_count - (AW+1)'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wptr] <= i_data;
  end

endmodule

// File: rtl/sudoku_cmd_exec.sv
// Sudoku cursor/command executor: scans the grid after reset, then executes
// buffered move/write commands through the synchronous cell RAM port.
module sudoku_cmd_exec
  import sudoku_pkg::*;
#(
  parameter int FIFO_DEPTH = 4
) (
  input  logic               clk,
  input  logic               reset,
  sudoku_cmd_exec_if.slave   bus
);

  localparam int         CW        = $clog2(FIFO_DEPTH) + 1;
  localparam logic [6:0] N_CELLS   = 7'(CELLS);
  localparam logic [6:0] LAST_CELL = 7'(CELLS - 1);
  localparam logic [3:0] MAX_POS   = 4'(GRID_N - 1);

  state_t          r_state;
  state_t          w_next;
  logic [6:0]      r_scan_cnt;
  logic [6:0]      r_filled;
  logic [3:0]      r_x;
  logic [3:0]      r_y;
  logic [3:0]      r_val;
  logic            r_ready;
  cmd_t            r_cmd;
  cmd_t            w_cmd_in;
  cmd_t            w_cmd_head;
  logic            w_full;
  logic            w_empty;
  logic            w_push;
  logic            w_pop;
  logic [CW-1:0]   w_count;
  logic            w_is_move;
  logic            w_illegal;
  logic            w_write_ok;
  logic            w_in_check;

  function automatic logic [3:0] wrap_dec(logic [3:0] v);
    return (v == 4'd0) ? MAX_POS : v - 4'd1;
  endfunction

  function automatic logic [3:0] wrap_inc(logic [3:0] v);
    return (v == MAX_POS) ? 4'd0 : v + 4'd1;
  endfunction

  // Count tracks zero<->non-zero transitions only, clamped to the grid size
  function automatic logic [6:0] adj_filled(logic [6:0] cnt, logic [3:0] old_v,
                                            logic [3:0] new_v);
    if (old_v == 4'd0 && new_v != 4'd0 && cnt < N_CELLS) return cnt + 7'd1;
    if (old_v != 4'd0 && new_v == 4'd0 && cnt != 7'd0) return cnt - 7'd1;
    return cnt;
  endfunction

  assign w_cmd_in = {bus.cmd_up, bus.cmd_down, bus.cmd_left, bus.cmd_right,
                     bus.cmd_number};
  assign w_push   = bus.cmd_valid;
  assign w_pop    = (r_state == ST_IDLE) && !w_empty;

  sudoku_cmd_fifo #(.FIFO_DEPTH(FIFO_DEPTH)) u_fifo (
    .clk     (clk),
    .reset   (reset),
    .i_push  (w_push),
    .i_pop   (w_pop),
    .i_data  (w_cmd_in),
    .o_data  (w_cmd_head),
    .o_full  (w_full),
    .o_empty (w_empty),
    .o_count (w_count)
  );

  assign w_is_move  = r_cmd.up || r_cmd.down || r_cmd.left || r_cmd.right;
  assign w_illegal  = (r_cmd.number > 4'd9);
  assign w_in_check = (r_state == ST_CHECK);
  assign w_write_ok = w_in_check && !w_is_move && !bus.cell_fixed && !w_illegal;

  assign bus.cell_addr    = (r_state == ST_SCAN)
                            ? ((r_scan_cnt > LAST_CELL) ? LAST_CELL : r_scan_cnt)
                            : cell_index(r_x, r_y);
  assign bus.cell_we      = w_write_ok && !reset;
  assign bus.cell_wdata   = r_cmd.number;
  assign bus.cmd_err      = w_in_check && !w_is_move && !bus.cell_fixed && w_illegal
                            && !reset;
  assign bus.cmd_drop     = bus.cmd_valid && w_full && !reset;
  assign bus.cur_x        = r_x;
  assign bus.cur_y        = r_y;
  assign bus.cur_val      = r_val;
  assign bus.filled_count = r_filled;
  assign bus.grid_full    = (r_filled == N_CELLS);
  assign bus.ready        = r_ready;
  assign bus.busy         = (r_state != ST_IDLE);

  always_comb begin
    w_next = r_state;
    case (r_state)
      ST_SCAN:  if (r_scan_cnt == N_CELLS) w_next = ST_IDLE;
      ST_IDLE:  if (w_count != '0) w_next = ST_EXEC;
      ST_EXEC:  w_next = ST_ADDR;
      ST_ADDR:  w_next = ST_CHECK;
      ST_CHECK: w_next = ST_IDLE;
      default:  w_next = ST_SCAN;
    endcase
  end

  // Scan data for address n arrives while the counter reads n+1
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state    <= ST_SCAN;
      r_scan_cnt <= '0;
      r_x        <= '0;
      r_y        <= '0;
      r_val      <= '0;
      r_filled   <= '0;
      r_ready    <= 1'b0;
    end else begin
      r_state <= w_next;
      case (r_state)
        ST_SCAN: begin
          r_scan_cnt <= r_scan_cnt + 7'd1;
          if (r_scan_cnt != 7'd0 && bus.cell_rdata != 4'd0) r_filled <= r_filled + 7'd1;
          if (r_scan_cnt == 7'd1) r_val <= bus.cell_rdata;
          if (r_scan_cnt == N_CELLS) r_ready <= 1'b1;
        end
        ST_EXEC: begin
          if (r_cmd.up)         r_y <= wrap_dec(r_y);
          else if (r_cmd.down)  r_y <= wrap_inc(r_y);
          else if (r_cmd.left)  r_x <= wrap_dec(r_x);
          else if (r_cmd.right) r_x <= wrap_inc(r_x);
        end
        ST_CHECK: begin
          if (w_write_ok) begin
            r_val    <= r_cmd.number;
            r_filled <= adj_filled(r_filled, bus.cell_rdata, r_cmd.number);
          end else begin
            r_val <= bus.cell_rdata;
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (w_pop) r_cmd <= w_cmd_head;
  end

endmodule

// File: tb/tb_sudoku_cmd_exec.sv
// Bench for sudoku_cmd_exec: synchronous RAM model plus a grid/cursor reference
// model driven by directed and random command sequences.
module tb_sudoku_cmd_exec;
  import sudoku_pkg::*;

  localparam logic [7:0] C_UP    = 8'h80;
  localparam logic [7:0] C_DOWN  = 8'h40;
  localparam logic [7:0] C_LEFT  = 8'h20;
  localparam logic [7:0] C_RIGHT = 8'h10;

  logic clk = 1'b0;
  logic reset = 1'b1;
  int   errors = 0;
  int   checks = 0;
  int   n_we = 0;
  int   n_err = 0;
  int   n_drop = 0;
  logic [3:0] ram     [CELLS];
  logic       fixed_m [CELLS];
  logic [3:0] mgrid   [CELLS];
  int   mx = 0;
  int   my = 0;

  always #5 clk = ~clk;

  sudoku_cmd_exec_if bus();

  sudoku_cmd_exec #(.FIFO_DEPTH(4)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  // Synchronous-read cell RAM with fixed-clue flags
  always @(posedge clk) begin
    if (bus.cell_we) n_we++;
    if (bus.cmd_err) n_err++;
    if (bus.cmd_drop) n_drop++;
    if (int'(bus.cell_addr) < CELLS) begin
      bus.cell_rdata <= ram[bus.cell_addr];
      bus.cell_fixed <= fixed_m[bus.cell_addr];
      if (bus.cell_we) ram[bus.cell_addr] = bus.cell_wdata;
    end
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic drive_cmd(input logic [7:0] c);
    bus.cmd_up     = c[7];
    bus.cmd_down   = c[6];
    bus.cmd_left   = c[5];
    bus.cmd_right  = c[4];
    bus.cmd_number = c[3:0];
    bus.cmd_valid  = 1'b1;
  endtask

  task automatic clear_cmd;
    bus.cmd_up = 0; bus.cmd_down = 0; bus.cmd_left = 0; bus.cmd_right = 0;
    bus.cmd_number = 0; bus.cmd_valid = 0;
  endtask

  function automatic int model_filled();
    int n = 0;
    for (int i = 0; i < CELLS; i++) if (mgrid[i] != 4'd0) n++;
    return n;
  endfunction

  function automatic bit ram_matches();
    for (int i = 0; i < CELLS; i++) if (ram[i] !== mgrid[i]) return 1'b0;
    return 1'b1;
  endfunction

  function automatic logic [7:0] rand_cmd();
    logic [3:0] dir;
    dir = ($urandom_range(0, 7) < 4) ? 4'($urandom_range(0, 15)) : 4'd0;
    return {dir, 4'($urandom_range(0, 15))};
  endfunction

  // Reference: moves wrap on a 9x9 torus with up>down>left>right priority;
  // writes land unless the cell is a clue or the digit is out of range.
  task automatic model_apply(input logic [7:0] c, output int we, output int er);
    int i;
    we = 0; er = 0;
    if (c[7])      my = (my + 8) % 9;
    else if (c[6]) my = (my + 1) % 9;
    else if (c[5]) mx = (mx + 8) % 9;
    else if (c[4]) mx = (mx + 1) % 9;
    else begin
      i = my * 9 + mx;
      if (!fixed_m[i]) begin
        if (c[3:0] > 4'd9) er = 1;
        else begin
          mgrid[i] = c[3:0];
          we = 1;
        end
      end
    end
  endtask

  task automatic run_cmd(input logic [7:0] c, output int we, output int er);
    drive_cmd(c);
    tick;
    clear_cmd;
    repeat (5) tick;
    model_apply(c, we, er);
  endtask

  task automatic wait_ready(input string tag);
    int k = 0;
    while (!bus.ready && k < 200) begin tick; k++; end
    checks++;
    if (bus.ready !== 1'b1) begin
      errors++;
      $display("FAIL %s_ready_timeout: ready=%b want 1 after %0d cycles", tag, bus.ready, k);
    end
  endtask

  task automatic setup_grid;
    int placed, i;
    for (int j = 0; j < CELLS; j++) begin ram[j] = 4'd0; fixed_m[j] = 1'b0; end
    ram[0] = 4'd5; ram[80] = 4'd4; ram[78] = 4'd2; fixed_m[78] = 1'b1;
    placed = 3;
    while (placed < 30) begin
      i = $urandom_range(1, 77);
      if (ram[i] == 4'd0) begin
        ram[i] = 4'($urandom_range(1, 9));
        fixed_m[i] = ($urandom_range(0, 3) == 0);
        placed++;
      end
    end
    for (int j = 0; j < CELLS; j++) mgrid[j] = ram[j];
  endtask

  task automatic test_reset;
    setup_grid;
    reset = 1'b1;
    tick; tick;
    checks++;
    if ({bus.cur_x, bus.cur_y, bus.cur_val, bus.filled_count, bus.ready, bus.busy,
         bus.cmd_drop, bus.cmd_err, bus.cell_we} !== {12'h000, 7'd0, 5'b01000}) begin
      errors++;
      $display("FAIL reset_outputs: got x=%0d y=%0d val=%0d filled=%0d rdy=%b busy=%b drop=%b err=%b we=%b want zeros busy=1",
               bus.cur_x, bus.cur_y, bus.cur_val, bus.filled_count, bus.ready, bus.busy,
               bus.cmd_drop, bus.cmd_err, bus.cell_we);
    end
    reset = 1'b0;
    mx = 0; my = 0;
    checks++;
    if (bus.cell_addr !== 7'd0) begin
      errors++; $display("FAIL scan_start_addr: got %0d want 0", bus.cell_addr);
    end
    repeat (81) tick;
    checks++;
    if ({bus.ready, bus.busy} !== 2'b01) begin
      errors++; $display("FAIL ready_cycle81: got rdy=%b busy=%b want 0 1", bus.ready, bus.busy);
    end
    tick;
    checks++;
    if ({bus.ready, bus.busy, bus.filled_count, bus.cur_val} !== {2'b10, 7'd30, 4'd5}) begin
      errors++;
      $display("FAIL ready_cycle82: got rdy=%b busy=%b filled=%0d val=%0d want 1 0 30 5",
               bus.ready, bus.busy, bus.filled_count, bus.cur_val);
    end
  endtask

  task automatic test_moves;
    int we, er;
    run_cmd(C_UP, we, er);
    checks++;
    if ({bus.cur_x, bus.cur_y, bus.cur_val} !== {4'(mx), 4'(my), mgrid[my*9+mx]}) begin
      errors++; $display("FAIL move_up_wrap: got (%0d,%0d) val=%0d want (%0d,%0d) val=%0d",
                         bus.cur_x, bus.cur_y, bus.cur_val, mx, my, mgrid[my*9+mx]);
    end
    drive_cmd(C_LEFT);
    tick;
    clear_cmd;
    repeat (4) tick;
    checks++;
    if ({bus.cur_x, bus.cur_y, bus.cur_val} !== {4'd8, 4'd8, ram[80]}) begin
      errors++; $display("FAIL move_left_wrap: got (%0d,%0d) val=%0d want (8,8) val=%0d",
                         bus.cur_x, bus.cur_y, bus.cur_val, ram[80]);
    end
    tick;
    model_apply(C_LEFT, we, er);
  endtask

  task automatic test_write;
    int we, er, f0;
    run_cmd(C_LEFT, we, er);
    f0 = model_filled();
    drive_cmd(8'h07);
    tick;
    clear_cmd;
    repeat (3) tick;
    checks++;
    if ({bus.cell_we, bus.cell_addr, bus.cell_wdata} !== {1'b1, 7'(my*9+mx), 4'd7}) begin
      errors++; $display("FAIL write7_strobe: got we=%b addr=%0d data=%0d want 1 %0d 7",
                         bus.cell_we, bus.cell_addr, bus.cell_wdata, my*9+mx);
    end
    tick;
    model_apply(8'h07, we, er);
    checks++;
    if ({bus.filled_count, bus.cur_val} !== {7'(f0 + 1), 4'd7}) begin
      errors++; $display("FAIL write7_count: got filled=%0d val=%0d want %0d 7",
                         bus.filled_count, bus.cur_val, f0 + 1);
    end
    tick;
    run_cmd(8'h00, we, er);
    checks++;
    if ({bus.filled_count, bus.cur_val, ram[my*9+mx]} !== {7'(f0), 4'd0, 4'd0}) begin
      errors++; $display("FAIL erase_count: got filled=%0d val=%0d ram=%0d want %0d 0 0",
                         bus.filled_count, bus.cur_val, ram[my*9+mx], f0);
    end
  endtask

  task automatic test_fixed_illegal;
    int we, er, f0, e0;
    run_cmd(C_LEFT, we, er);
    f0 = model_filled();
    e0 = n_err;
    drive_cmd(8'h09);
    tick; clear_cmd; repeat (3) tick;
    checks++;
    if ({bus.cell_we, bus.cmd_err} !== 2'b00) begin
      errors++; $display("FAIL fixed_write_strobe: got we=%b err=%b want 0 0", bus.cell_we, bus.cmd_err);
    end
    tick;
    model_apply(8'h09, we, er);
    checks++;
    if ({bus.cur_val, bus.filled_count} !== {mgrid[my*9+mx], 7'(f0)}) begin
      errors++; $display("FAIL fixed_write_state: got val=%0d filled=%0d want %0d %0d",
                         bus.cur_val, bus.filled_count, mgrid[my*9+mx], f0);
    end
    tick;
    run_cmd(C_RIGHT, we, er);
    drive_cmd(8'h0C);
    tick; clear_cmd; repeat (3) tick;
    checks++;
    if ({bus.cell_we, bus.cmd_err} !== 2'b01) begin
      errors++; $display("FAIL illegal_strobe: got we=%b err=%b want 0 1", bus.cell_we, bus.cmd_err);
    end
    tick;
    model_apply(8'h0C, we, er);
    checks++;
    if ({bus.cur_val, bus.filled_count, ram[my*9+mx]} !== {mgrid[my*9+mx], 7'(f0), 4'd0}) begin
      errors++; $display("FAIL illegal_state: got val=%0d filled=%0d ram=%0d want %0d %0d 0",
                         bus.cur_val, bus.filled_count, ram[my*9+mx], mgrid[my*9+mx], f0);
    end
    tick;
    checks++;
    if (n_err - e0 !== 1) begin
      errors++; $display("FAIL illegal_err_pulses: got %0d want 1", n_err - e0);
    end
  endtask

  task automatic test_back_to_back;
    logic [7:0] c [4];
    int we, er, exp_we = 0, exp_er = 0, w0 = n_we, e0 = n_err, d0 = n_drop;
    for (int k = 0; k < 4; k++) begin
      c[k] = rand_cmd();
      drive_cmd(c[k]);
      tick;
    end
    clear_cmd;
    repeat (24) tick;
    for (int k = 0; k < 4; k++) begin
      model_apply(c[k], we, er);
      exp_we += we; exp_er += er;
    end
    checks++;
    if ({n_drop - d0, n_we - w0, n_err - e0} !== {0, exp_we, exp_er}) begin
      errors++; $display("FAIL b2b_pulses: got drop=%0d we=%0d err=%0d want 0 %0d %0d",
                         n_drop - d0, n_we - w0, n_err - e0, exp_we, exp_er);
    end
    checks++;
    if ({bus.cur_x, bus.cur_y, bus.cur_val, bus.filled_count, ram_matches()} !==
        {4'(mx), 4'(my), mgrid[my*9+mx], 7'(model_filled()), 1'b1}) begin
      errors++; $display("FAIL b2b_state: got (%0d,%0d) val=%0d filled=%0d ramok=%b want (%0d,%0d) %0d %0d 1",
                         bus.cur_x, bus.cur_y, bus.cur_val, bus.filled_count, ram_matches(),
                         mx, my, mgrid[my*9+mx], model_filled());
    end
  endtask

  task automatic test_random;
    logic [7:0] c;
    int we, er, w0, e0;
    for (int k = 0; k < 40; k++) begin
      c = rand_cmd();
      w0 = n_we; e0 = n_err;
      run_cmd(c, we, er);
      checks++;
      if ({bus.cur_x, bus.cur_y, bus.cur_val, bus.filled_count, bus.grid_full,
           n_we - w0, n_err - e0} !==
          {4'(mx), 4'(my), mgrid[my*9+mx], 7'(model_filled()), model_filled() == CELLS, we, er}) begin
        errors++;
        $display("FAIL random_cmd%0d(%h): got (%0d,%0d) val=%0d filled=%0d full=%b we=%0d err=%0d want (%0d,%0d) %0d %0d %0d %0d",
                 k, c, bus.cur_x, bus.cur_y, bus.cur_val, bus.filled_count, bus.grid_full,
                 n_we - w0, n_err - e0, mx, my, mgrid[my*9+mx], model_filled(), we, er);
      end
    end
    checks++;
    if (!ram_matches()) begin
      errors++; $display("FAIL random_ram: got RAM differing from model want identical");
    end
  endtask

  task automatic test_scan_buffer;
    logic [7:0] c [6];
    int we, er, d0 = n_drop;
    c[0] = C_RIGHT; c[1] = C_DOWN; c[2] = 8'h03; c[3] = C_RIGHT; c[4] = C_UP; c[5] = C_UP;
    reset = 1'b1;
    tick; tick;
    reset = 1'b0;
    mx = 0; my = 0;
    for (int k = 0; k < 6; k++) begin
      drive_cmd(c[k]);
      tick;
    end
    clear_cmd;
    wait_ready("scanbuf");
    repeat (20) tick;
    for (int k = 0; k < 4; k++) model_apply(c[k], we, er);
    checks++;
    if (n_drop - d0 !== 2) begin
      errors++; $display("FAIL scanbuf_drops: got %0d want 2", n_drop - d0);
    end
    checks++;
    if ({bus.cur_x, bus.cur_y, bus.cur_val, bus.filled_count, ram_matches()} !==
        {4'(mx), 4'(my), mgrid[my*9+mx], 7'(model_filled()), 1'b1}) begin
      errors++; $display("FAIL scanbuf_state: got (%0d,%0d) val=%0d filled=%0d ramok=%b want (%0d,%0d) %0d %0d 1",
                         bus.cur_x, bus.cur_y, bus.cur_val, bus.filled_count, ram_matches(),
                         mx, my, mgrid[my*9+mx], model_filled());
    end
  endtask

  task automatic test_grid_full;
    int we, er;
    for (int j = 0; j < CELLS; j++) begin
      ram[j] = 4'($urandom_range(1, 9)); fixed_m[j] = 1'b0; mgrid[j] = ram[j];
    end
    reset = 1'b1;
    tick; tick;
    reset = 1'b0;
    mx = 0; my = 0;
    wait_ready("full");
    tick;
    checks++;
    if ({bus.filled_count, bus.grid_full} !== {7'd81, 1'b1}) begin
      errors++; $display("FAIL full_after_scan: got filled=%0d full=%b want 81 1", bus.filled_count, bus.grid_full);
    end
    run_cmd(8'h00, we, er);
    checks++;
    if ({bus.filled_count, bus.grid_full} !== {7'd80, 1'b0}) begin
      errors++; $display("FAIL full_erase: got filled=%0d full=%b want 80 0", bus.filled_count, bus.grid_full);
    end
    run_cmd(8'h06, we, er);
    run_cmd(8'h06, we, er);
    checks++;
    if ({bus.filled_count, bus.grid_full, bus.cur_val} !== {7'd81, 1'b1, 4'd6}) begin
      errors++; $display("FAIL full_rewrite: got filled=%0d full=%b val=%0d want 81 1 6",
                         bus.filled_count, bus.grid_full, bus.cur_val);
    end
  endtask

  task automatic test_reset_mid;
    int w0 = n_we;
    drive_cmd(8'h03); tick;
    drive_cmd(C_RIGHT); tick;
    drive_cmd(C_RIGHT); tick;
    clear_cmd; tick;
    checks++;
    if (bus.cell_we !== 1'b1) begin
      errors++; $display("FAIL midreset_precheck: got we=%b want 1", bus.cell_we);
    end
    reset = 1'b1;
    #1;
    checks++;
    if (bus.cell_we !== 1'b0) begin
      errors++; $display("FAIL midreset_we_forced: got we=%b want 0", bus.cell_we);
    end
    tick;
    reset = 1'b0;
    mx = 0; my = 0;
    checks++;
    if ({bus.cell_addr, bus.busy, bus.cur_x, bus.cur_y} !== {7'd0, 1'b1, 8'h00}) begin
      errors++; $display("FAIL midreset_rescan: got addr=%0d busy=%b (%0d,%0d) want 0 1 (0,0)",
                         bus.cell_addr, bus.busy, bus.cur_x, bus.cur_y);
    end
    wait_ready("midreset");
    repeat (12) tick;
    checks++;
    if ({bus.busy, bus.cur_x, bus.cur_y, bus.cur_val, bus.filled_count, n_we - w0, ram[0]} !==
        {1'b0, 8'h00, mgrid[0], 7'(model_filled()), 0, mgrid[0]}) begin
      errors++; $display("FAIL midreset_discard: got busy=%b (%0d,%0d) val=%0d filled=%0d we=%0d ram0=%0d want 0 (0,0) %0d %0d 0 %0d",
                         bus.busy, bus.cur_x, bus.cur_y, bus.cur_val, bus.filled_count, n_we - w0,
                         ram[0], mgrid[0], model_filled(), mgrid[0]);
    end
  endtask

  initial begin
    clear_cmd;
    reset = 1'b1;
    test_reset;
    test_moves;
    test_write;
    test_fixed_illegal;
    test_back_to_back;
    test_random;
    test_scan_buffer;
    test_grid_full;
    test_reset_mid;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time exceeded limit");
    $fatal(1, "watchdog");
  end

endmodule
